// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_pkg
//  Brief    : Shared state encoding and defaults for the clock divider slice.
//  Revision : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    localparam int c_cnt_w_default = 8;
    localparam int c_default_half  = 4;

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } state_t;

endpackage : clk_div_pkg
`default_nettype wire

// File: rtl/clk_div_core.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_core
//  Brief    : Half-period counter, toggle flop, edge ticks and active ratio.
//  Revision : 1.0 - initial release
// ============================================================================
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int CNT_W        = c_cnt_w_default,
    parameter int DEFAULT_HALF = c_default_half
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             clear,
    input  logic             cnt_en,
    input  logic             load_en,
    input  logic [CNT_W-1:0] load_half,
    output logic             term,
    output logic             clk_out,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic [CNT_W-1:0] cur_half
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_cur_half;
    logic             r_clk_out;
    logic             r_tick_rise;
    logic             r_tick_fall;

    // cur_half is never 0, so the subtraction cannot wrap
    assign term = (r_count == (r_cur_half - CNT_W'(1)));

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_count     <= '0;
            r_cur_half  <= CNT_W'(DEFAULT_HALF);
            r_clk_out   <= 1'b0;
            r_tick_rise <= 1'b0;
            r_tick_fall <= 1'b0;
        end else begin
            if (load_en) begin
                r_cur_half <= load_half;
            end
            r_tick_rise <= 1'b0;
            r_tick_fall <= 1'b0;
            if (clear) begin
                r_count   <= '0;
                r_clk_out <= 1'b0;
            end else if (cnt_en) begin
                if (term) begin
                    r_count     <= '0;
                    r_clk_out   <= ~r_clk_out;
                    r_tick_rise <= ~r_clk_out;
                    r_tick_fall <= r_clk_out;
                end else begin
                    r_count <= r_count + CNT_W'(1);
                end
            end
        end
    end

    assign clk_out   = r_clk_out;
    assign tick_rise = r_tick_rise;
    assign tick_fall = r_tick_fall;
    assign cur_half  = r_cur_half;

endmodule : clk_div_core
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_ctrl
//  Brief    : Run/stop sequencing and ratio-change handshake for the divider.
//  Revision : 1.0 - initial release
// ============================================================================
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W        = c_cnt_w_default,
    parameter int DEFAULT_HALF = c_default_half
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic             running,
    output logic [CNT_W-1:0] cur_half
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_pend_valid;
    logic [CNT_W-1:0] r_pend_half;
    logic             r_cfg_err;
    logic             w_xfer;
    logic             w_cfg_zero;
    logic             w_clear;
    logic             w_cnt_en;
    logic             w_load;
    logic             w_term;
    logic             w_clk_out;

    assign cfg_ready  = ~r_pend_valid;
    assign w_xfer     = cfg_valid & ~r_pend_valid;
    assign w_cfg_zero = (cfg_half == '0);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state      <= ST_STOP;
            r_pend_valid <= 1'b0;
            r_pend_half  <= '0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cfg_err <= w_xfer & w_cfg_zero;
            // load and accept are mutually exclusive: one needs pend_valid set, the other clear
            if (w_load) begin
                r_pend_valid <= 1'b0;
            end else if (w_xfer && !w_cfg_zero) begin
                r_pend_valid <= 1'b1;
                r_pend_half  <= cfg_half;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_cnt_en    = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_STOP: begin
                w_clear = 1'b1;
                w_load  = r_pend_valid;
                if (en) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_cnt_en = 1'b1;
                w_load   = r_pend_valid & w_term & w_clk_out;
                if (!en) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_cnt_en = 1'b1;
                // ratio may change at the high->low boundary or at the final low edge
                w_load   = r_pend_valid & w_term & (w_clk_out | ~en);
                if (en) begin
                    w_state_nxt = ST_RUN;
                end else if (w_term && !w_clk_out) begin
                    w_state_nxt = ST_STOP;
                    w_clear     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_STOP;
            end
        endcase
    end

    clk_div_core #(
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (DEFAULT_HALF)
    ) u_core (
        .clk_in    (clk_in),
        .reset     (reset),
        .clear     (w_clear),
        .cnt_en    (w_cnt_en),
        .load_en   (w_load),
        .load_half (r_pend_half),
        .term      (w_term),
        .clk_out   (w_clk_out),
        .tick_rise (tick_rise),
        .tick_fall (tick_fall),
        .cur_half  (cur_half)
    );

    assign clk_out = w_clk_out;
    assign cfg_err = r_cfg_err;
    assign running = (r_state != ST_STOP);

endmodule : clk_div_ctrl
`default_nettype wire

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Controller for the toggle-style clock divider used throughout the design. It owns the divided-clock counter and sequences run/stop and divide-ratio changes so that every emitted period is complete and glitch-free. Software/upstream logic requests a new half-period over a valid/ready handshake. The controller applies the new ratio only at a full-period boundary and reports edge ticks for downstream single-clock logic.

Parameters:
CNT_W, 8, width of the half-period count and config value
DEFAULT_HALF, 4, half-period in clk_in cycles after reset (4 = divide-by-8)

Ports:
clk_in  input  1  sole clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
en  input  1  run request; 1 = generate clk_out, 0 = stop after current period
cfg_valid  input  1  new half-period offered
cfg_half  input  CNT_W  requested half-period in clk_in cycles; 0 is illegal
cfg_ready  output  1  controller can accept a config (no config pending)
cfg_err  output  1  one-cycle pulse: cfg_half==0 offered and dropped
clk_out  output  1  divided clock, registered
tick_rise  output  1  one-cycle pulse in the first cycle clk_out==1
tick_fall  output  1  one-cycle pulse in the first cycle clk_out==0 after a high phase
running  output  1  1 in RUN or DRAIN
cur_half  output  CNT_W  half-period currently in effect

Behaviour:
- Reset (sync, priority over all): state=STOP, count=0, clk_out=0, cur_half=DEFAULT_HALF, pend_valid=0, cfg_ready=1, cfg_err=0, tick_rise=0, tick_fall=0, running=0.
- Handshake: transfer when cfg_valid && cfg_ready.
  - cfg_half!=0: store in pend_half and set pend_valid. cfg_ready=!pend_valid, so it drops the next cycle.
  - cfg_half==0: transfer completes, value discarded, cfg_err=1 next cycle, pend_valid unchanged.
- States:
  - STOP: count=0, clk_out=0. If pend_valid, cur_half<=pend_half and pend_valid<=0 in one cycle. When en=1, go to RUN with count=0 and clk_out=0. Pending apply and en in the same cycle: apply first, so RUN starts with the new value.
  - RUN: count increments each cycle. When count==cur_half-1: count<=0, clk_out<=~clk_out.
    - High→low toggle is the period boundary. If pend_valid was set before this cycle, cur_half<=pend_half and pend_valid<=0.
    - A config accepted in the boundary cycle itself waits for the next boundary.
    - en=0 during the high phase: go to DRAIN.
    - en=0 during the low phase: finish the low phase in DRAIN (count continues), then STOP.
  - DRAIN: identical counting to RUN. On reaching the period end (clk_out low and count==cur_half-1), go to STOP with count=0 and clk_out=0. Pending config applied at that boundary. en=1 again during DRAIN: return to RUN with no discontinuity in count or clk_out.
- Output timing: clk_out is high for exactly cur_half cycles and low for exactly cur_half cycles. First high phase begins cur_half cycles after RUN entry (low phase first).
- Ticks: registered alongside the clk_out toggle, so they coincide with the new clk_out level. No ticks in STOP.
- Width rules: count is CNT_W bits. Compare against cur_half-1 with no wrap for cur_half>=1. cur_half=1 gives divide-by-2. cur_half=2^CNT_W-1 is the maximum.
- cfg_ready stays low until the pending value is applied; there is no overwrite of a pending value.
- en toggled while pend_valid=1 has no effect on pending state.

Decomposition:
- Shared package clk_div_pkg holds:
  - state enum (STOP, RUN, DRAIN)
  - CNT_W default
  - DEFAULT_HALF
- One natural sub-module, clk_div_core: count register, compare, clk_out toggle, tick generation. Inputs: load enable and half value.
- clk_div_ctrl keeps the FSM, pending register and handshake.

Test Plan:
- Reset, en=1, DEFAULT_HALF=4 → clk_out low cycles 1–4 after RUN entry, high 5–8; tick_rise at cycle 5, tick_fall at cycle 9; period 8.
- Mid-high-phase config cfg_half=2 → cfg_ready drops next cycle. Current high and low phases remain 4; first new-ratio period is 2 high / 2 low; cfg_ready returns 1 the cycle after the boundary.
- cfg_half=0 offered → cfg_err pulses once; cur_half unchanged at 4; cfg_ready stays 1.
- en=0 two cycles into the high phase → remaining high cycles plus 4 low cycles, then STOP with clk_out=0 and running=0. en re-asserted during DRAIN → continuous waveform, no short phase.
- Config cfg_half=1 in STOP, then en=1 → clk_out toggles every cycle (divide-by-2); tick_rise every 2 cycles.
- Reset asserted mid-high-phase with pend_valid=1 → next cycle all outputs at reset values, cur_half=4, pending discarded.
